// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier dispatch wrapper: operand/result
// widths and the dispatch FSM state encoding.
package mult_pkg;

    localparam int OP_W  = 8;
    localparam int RES_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    // Queue entries carry {x, y}; x occupies the upper byte.
    function automatic logic [2*OP_W-1:0] pack_ops(input logic [OP_W-1:0] x,
                                                   input logic [OP_W-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/mult_dispatch_if.sv
// Bundle of the upstream operand handshake, the multiplier control/datapath
// bus and the downstream result handshake around mult_dispatch.
// master = the dispatch wrapper, slave = its surroundings.
interface mult_dispatch_if;
    import mult_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_x;
    logic [OP_W-1:0]   in_y;
    logic [OP_W-1:0]   mul_x;
    logic [OP_W-1:0]   mul_y;
    logic              mul_start;
    logic              mul_rst;
    logic              mul_done;
    logic [RES_W-1:0]  mul_res;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_res;
    logic              busy;
    logic              err;

    modport master (
        input  in_valid, in_x, in_y, mul_done, mul_res, out_ready,
        output in_ready, mul_x, mul_y, mul_start, mul_rst,
               out_valid, out_res, busy, err
    );

    modport slave (
        output in_valid, in_x, in_y, mul_done, mul_res, out_ready,
        input  in_ready, mul_x, mul_y, mul_start, mul_rst,
               out_valid, out_res, busy, err
    );

endinterface

// File: rtl/op_fifo.sv
// Operand pair queue: power-of-two depth, wrapping pointers, occupancy
// counter one bit wider than the pointers so full and empty are distinct.
module op_fifo
    import mult_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2 * OP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    // A push while full is dropped even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset since count_q gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mult_dispatch.sv
// Front/back-end wrapper for the 8-bit multiplier and its control unit.
// Queues operand pairs, issues one multiply at a time with a start pulse,
// captures the product on DONE and parks the control unit back in IDLE with
// a clear pulse (it otherwise sits in its final state until reset).
// Optional build macro MULT_TIMEOUT_EN: bounds the wait for DONE to TIMEOUT
// cycles, drops the operation on expiry and raises a sticky err flag.
module mult_dispatch
    import mult_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic            clk,
    input  logic            RESET,
    mult_dispatch_if.master bus
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_param_check
        $error("mult_dispatch: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    state_t              state;
    logic [OP_W-1:0]     mul_x_q;
    logic [OP_W-1:0]     mul_y_q;
    logic                mul_start_q;
    logic                mul_rst_q;
    logic                out_valid_q;
    logic [RES_W-1:0]    out_res_q;
    logic                busy_q;

    logic [2*OP_W-1:0]   head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                slot_free;

`ifdef MULT_TIMEOUT_EN
    localparam int         CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0]      wait_cnt;
    logic                  err_q;
`endif

    assign push      = bus.in_valid && !fifo_full;
    assign pop       = (state == IDLE) && !fifo_empty;
    assign slot_free = !out_valid_q || bus.out_ready;

    op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * OP_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (RESET),
        .push  (push),
        .pop   (pop),
        .din   (pack_ops(bus.in_x, bus.in_y)),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Dispatch FSM; every output it drives is registered here.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
            mul_start_q <= 1'b0;
            mul_rst_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            busy_q      <= 1'b0;
`ifdef MULT_TIMEOUT_EN
            wait_cnt    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            mul_start_q <= 1'b0;
            mul_rst_q   <= 1'b0;
            // Drain handshake; a capture below in the same cycle overrides it.
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state       <= ISSUE;
                        mul_x_q     <= head[2*OP_W-1:OP_W];
                        mul_y_q     <= head[OP_W-1:0];
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef MULT_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    // DONE is sticky, so waiting for a free slot loses nothing.
                    if (bus.mul_done && slot_free) begin
                        out_res_q   <= bus.mul_res;
                        out_valid_q <= 1'b1;
                        mul_rst_q   <= 1'b1;
                        state       <= CLEAR;
                    end
`ifdef MULT_TIMEOUT_EN
                    else if (!bus.mul_done && (wait_cnt == CNT_LAST)) begin
                        err_q     <= 1'b1;
                        mul_rst_q <= 1'b1;
                        state     <= CLEAR;
                    end else if (!bus.mul_done) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                CLEAR: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = !fifo_full;
    assign bus.mul_x     = mul_x_q;
    assign bus.mul_y     = mul_y_q;
    assign bus.mul_start = mul_start_q;
    assign bus.mul_rst   = mul_rst_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_res   = out_res_q;
    assign bus.busy      = busy_q;
`ifdef MULT_TIMEOUT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_mult_dispatch.sv
// Scoreboard bench for mult_dispatch. A behavioural control unit answers
// mul_start with a sticky DONE after N_MUL cycles; expected products are
// hand-computed constants queued when each pair is offered, and a monitor
// pops them whenever a result is handed downstream.
// With MULT_TIMEOUT_EN defined the timeout scenario is exercised as well.
module tb_mult_dispatch;
    import mult_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;
    localparam int N_MUL   = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_dispatch_if bus ();

    mult_dispatch #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int          checks    = 0;
    int          errors    = 0;
    int          start_cnt = 0;
    int          clr_cnt   = 0;
    bit          hang      = 1'b0;
    bit          to_mode   = 1'b0;
    logic [15:0] sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural control unit + datapath.
    initial begin
        logic [7:0] ox, oy;
        bit         active;
        int         mcnt;
        bus.mul_done = 1'b0;
        bus.mul_res  = '0;
        active = 1'b0;
        mcnt   = 0;
        ox     = '0;
        oy     = '0;
        forever begin
            @(negedge clk);
            if (rst || bus.mul_rst) begin
                bus.mul_done = 1'b0;
                active       = 1'b0;
            end else if (bus.mul_start) begin
                active = 1'b1;
                mcnt   = 0;
                ox     = bus.mul_x;
                oy     = bus.mul_y;
            end else if (active && !bus.mul_done && !hang) begin
                mcnt++;
                if (mcnt == N_MUL) begin
                    bus.mul_res  = {8'd0, ox} * {8'd0, oy};
                    bus.mul_done = 1'b1;
                end
            end
        end
    end

    // Monitor: pulse shapes, operand hold and result scoreboard.
    initial begin
        logic [7:0]  hx, hy;
        logic [15:0] exp;
        bit          prev_start, prev_clr;
        hx = '0; hy = '0; prev_start = 0; prev_clr = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_start = 0;
                prev_clr   = 0;
            end else begin
                if (bus.mul_start) begin
                    start_cnt++;
                    check("start_single_cycle", 32'(prev_start), 0);
                    hx = bus.mul_x;
                    hy = bus.mul_y;
                end
                if (bus.mul_rst) begin
                    clr_cnt++;
                    check("clear_single_cycle", 32'(prev_clr), 0);
                    check("hold_x", 32'(bus.mul_x), 32'(hx));
                    check("hold_y", 32'(bus.mul_y), 32'(hy));
                    check("busy_in_clear", 32'(bus.busy), 1);
                    if (!to_mode) check("valid_in_clear", 32'(bus.out_valid), 1);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 32'(bus.out_res), 32'hFFFF_FFFF);
                    end else begin
                        exp = sb.pop_front();
                        check("result", 32'(bus.out_res), 32'(exp));
                    end
                end
                prev_start = bus.mul_start;
                prev_clr   = bus.mul_rst;
            end
        end
    end

    // Offer one pair; call just after a rising edge. Returns just after the
    // edge that accepted it.
    task automatic push(input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp, input bit track);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_y     = y;
        @(negedge clk);
        while (!bus.in_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) check("push_timeout", 0, 1);
        else if (track) sb.push_back(exp);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        bit done;
        done = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            done = !bus.busy && dut.fifo_empty && !bus.out_valid && (sb.size() == 0);
        end
        check(name, 32'(done), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_signal_start();
        int n = 0;
        while (!bus.mul_start && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.mul_start) check("start_timeout", 0, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mul_x"},     32'(bus.mul_x), 0);
        check({tag, "_mul_y"},     32'(bus.mul_y), 0);
        check({tag, "_mul_start"}, 32'(bus.mul_start), 0);
        check({tag, "_mul_rst"},   32'(bus.mul_rst), 0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_out_res"},   32'(bus.out_res), 0);
        check({tag, "_busy"},      32'(bus.busy), 0);
        check({tag, "_err"},       32'(bus.err), 0);
        check({tag, "_in_ready"},  32'(bus.in_ready), 1);
        check({tag, "_count"},     32'(dut.u_fifo.count_q), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, c0, n;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.out_ready = 1'b0;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single multiply
        bus.out_ready = 1'b1;
        s0 = start_cnt;
        c0 = clr_cnt;
        push(8'd13, 8'd11, 16'h008F, 1);
        wait_idle("t1_drain");
        check("t1_starts", 32'(start_cnt - s0), 1);
        check("t1_clears", 32'(clr_cnt - c0), 1);
        check("t1_busy", 32'(bus.busy), 0);
        check("t1_out_res", 32'(bus.out_res), 32'h008F);

        // Max operands
        push(8'd255, 8'd255, 16'hFE01, 1);
        wait_idle("t2_drain");
        check("t2_out_res", 32'(bus.out_res), 32'hFE01);

        // Backpressure
        bus.out_ready = 1'b0;
        s0 = start_cnt;
        fork
            begin
                push(8'd1, 8'd1, 16'd1, 1);
                push(8'd2, 8'd2, 16'd4, 1);
                push(8'd3, 8'd3, 16'd9, 1);
                push(8'd4, 8'd4, 16'd16, 1);
                push(8'd5, 8'd5, 16'd25, 1);
                push(8'd6, 8'd6, 16'd36, 1);
            end
            begin
                n = 0;
                @(negedge clk);
                while (!(bus.mul_done && bus.out_valid && !bus.mul_rst && bus.busy) && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                repeat (3) @(negedge clk);
                check("t3_stall_busy", 32'(bus.busy), 1);
                check("t3_stall_no_clear", 32'(bus.mul_rst), 0);
                check("t3_in_ready", 32'(bus.in_ready), 0);
                check("t3_count", 32'(dut.u_fifo.count_q), 4);
                check("t3_held_res", 32'(bus.out_res), 1);
                check("t3_held_valid", 32'(bus.out_valid), 1);
            end
        join
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_idle("t3_drain");
        check("t3_starts", 32'(start_cnt - s0), 6);

        // Simultaneous push and pop, then enough traffic to wrap the pointers
        push(8'd2, 8'd3, 16'd6, 1);
        push(8'd4, 8'd5, 16'd20, 1);
        push(8'd6, 8'd7, 16'd42, 1);
        check("t4_count_pre", 32'(dut.u_fifo.count_q), 2);
        n = 0;
        @(negedge clk);
        while (!bus.mul_rst && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t4_saw_clear", 32'(bus.mul_rst), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_x     = 8'd8;
        bus.in_y     = 8'd9;
        sb.push_back(16'd72);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("t4_count_simul", 32'(dut.u_fifo.count_q), 2);
        check("t4_dispatch", 32'(bus.mul_start), 1);
        push(8'd10, 8'd11, 16'd110, 1);
        push(8'd12, 8'd13, 16'd156, 1);
        push(8'd14, 8'd15, 16'd210, 1);
        push(8'd16, 8'd17, 16'h0110, 1);
        wait_idle("t4_drain");

        // Reset in the middle of WAIT with a pair still queued
        push(8'd9, 8'd9, 16'd0, 0);
        push(8'd2, 8'd2, 16'd0, 0);
        @(negedge clk);
        wait_signal_start();
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_values("t5_midreset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push(8'd3, 8'd7, 16'h0015, 1);
        wait_idle("t5_drain");
        check("t5_out_res", 32'(bus.out_res), 32'h0015);

`ifdef MULT_TIMEOUT_EN
        // Timeout: DONE never arrives
        to_mode = 1'b1;
        hang    = 1'b1;
        c0      = clr_cnt;
        push(8'd5, 8'd5, 16'd0, 0);
        @(negedge clk);
        wait_signal_start();
        @(posedge clk);
        n = 0;
        while (!bus.err && n < TIMEOUT + 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_err_latency", 32'(n), 32'(TIMEOUT));
        check("t6_clear_pulse", 32'(bus.mul_rst), 1);
        check("t6_no_valid", 32'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        check("t6_back_idle", 32'(bus.busy), 0);
        check("t6_clears", 32'(clr_cnt - c0), 1);
        hang    = 1'b0;
        to_mode = 1'b0;
        push(8'd6, 8'd7, 16'd42, 1);
        wait_idle("t6_drain");
        check("t6_err_sticky", 32'(bus.err), 1);
        check("t6_out_res", 32'(bus.out_res), 32'd42);
`else
        check("err_tied_low", 32'(bus.err), 0);
`endif

        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
